// File: rtl/encoder_level.sv
`default_nettype none
// ============================================================================
// Module   : encoder_level
// Purpose  : Quadrature encoder to 8-bit PWM level (sync, debounce, step).
// Revision : 1.0
// ============================================================================
module encoder_level #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         STEP            = 1,
  parameter bit         SATURATE        = 1'b1,
  parameter logic [7:0] RESET_LEVEL     = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic [7:0] level,
  output logic       step_up,
  output logic       step_down
);

  localparam int             CW         = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [8:0]     C_STEP     = 9'(STEP);

  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] db_w;
  logic       a_prev_q;
  logic [7:0] level_q;
  logic [7:0] level_d;
  logic       step_up_q;
  logic       step_up_d;
  logic       step_down_q;
  logic       step_down_d;
  logic [8:0] sum_w;
  logic [8:0] diff_w;
  logic       detent_w;

  // Bit 0 carries contact A, bit 1 carries contact B.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {enc_b, enc_a};
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_debounce
    logic [CW-1:0] cnt_q;
    logic          db_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else if (sync2_q[g] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == C_CNT_LAST) begin
        db_q  <= sync2_q[g];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign db_w[g] = db_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_prev_q <= 1'b0;
    end else begin
      a_prev_q <= db_w[0];
    end
  end

  assign detent_w = db_w[0] & ~a_prev_q;
  // Bit 8 of the 9-bit intermediates flags overflow (sum) or underflow (diff).
  assign sum_w    = {1'b0, level_q} + C_STEP;
  assign diff_w   = {1'b0, level_q} - C_STEP;

  always_comb begin
    level_d     = level_q;
    step_up_d   = 1'b0;
    step_down_d = 1'b0;
    if (detent_w) begin
      if (db_w[1]) begin
        step_down_d = 1'b1;
        if (diff_w[8] && SATURATE) begin
          level_d = 8'd0;
        end else begin
          level_d = diff_w[7:0];
        end
      end else begin
        step_up_d = 1'b1;
        if (sum_w[8] && SATURATE) begin
          level_d = 8'hFF;
        end else begin
          level_d = sum_w[7:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q     <= RESET_LEVEL;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      step_up_q   <= step_up_d;
      step_down_q <= step_down_d;
    end
  end

  assign level     = level_q;
  assign step_up   = step_up_q;
  assign step_down = step_down_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_level.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_level
// Purpose  : Directed, table-driven bench for encoder_level.
// Revision : 1.0
// ============================================================================
module tb_encoder_level;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_a, enc_b;
  logic       w_a, w_b;
  logic [7:0] level, w_level;
  logic       step_up, step_down, w_up, w_down;

  int n_cmp = 0;
  int n_bad = 0;
  int ups, dns, wups, wdns, both;

  encoder_level dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .level(level), .step_up(step_up), .step_down(step_down)
  );

  encoder_level #(
    .DEBOUNCE_CYCLES(4), .STEP(16), .SATURATE(1'b0), .RESET_LEVEL(8'd240)
  ) dut_wrap (
    .clk(clk), .reset(reset), .enc_a(w_a), .enc_b(w_b),
    .level(w_level), .step_up(w_up), .step_down(w_down)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic [7:0] exp_level;
    int         exp_up;
    int         exp_dn;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges; sample and drive only on falling edges.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      ups  += int'(step_up);
      dns  += int'(step_down);
      wups += int'(w_up);
      wdns += int'(w_down);
      if ((step_up && step_down) || (w_up && w_down)) both++;
    end
  endtask

  task automatic clr();
    ups = 0; dns = 0; wups = 0; wdns = 0;
  endtask

  task automatic detent();
    enc_a = 1'b1;
    cyc(10);
    enc_a = 1'b0;
    cyc(10);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'd2, 1, 0};
    vecs[1] = '{1'b0, 8'd3, 1, 0};
    vecs[2] = '{1'b1, 8'd2, 0, 1};
    vecs[3] = '{1'b1, 8'd1, 0, 1};
    vecs[4] = '{1'b1, 8'd0, 0, 1};
    vecs[5] = '{1'b1, 8'd0, 0, 1};
    vecs[6] = '{1'b0, 8'd1, 1, 0};

    both = 0;
    clr();
    reset = 1'b1;
    enc_a = 1'b1; enc_b = 1'b1;
    w_a = 1'b0;   w_b = 1'b0;
    @(negedge clk);
    cyc(3);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_up", 32'(step_up), 32'd0);
    chk("reset_down", 32'(step_down), 32'd0);
    chk("reset_wrap_level", 32'(w_level), 32'd240);

    // Release with A high and B low: detent up lands on edge 7.
    reset = 1'b0;
    enc_b = 1'b0;
    clr();
    cyc(6);
    chk("lat_edge6_level", 32'(level), 32'd0);
    chk("lat_edge6_up", 32'(step_up), 32'd0);
    cyc(1);
    chk("lat_edge7_level", 32'(level), 32'd1);
    chk("lat_edge7_up", 32'(step_up), 32'd1);
    cyc(1);
    chk("lat_edge8_up", 32'(step_up), 32'd0);
    enc_a = 1'b0;
    cyc(12);
    chk("lat_total_up", 32'(ups), 32'd1);

    for (int i = 0; i < 7; i++) begin
      enc_b = vecs[i].b;
      cyc(10);
      clr();
      detent();
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d_up", i), 32'(ups), 32'(vecs[i].exp_up));
      chk($sformatf("vec%0d_down", i), 32'(dns), 32'(vecs[i].exp_dn));
    end

    // Bounce 1,0,1,0 then hold high: exactly one step.
    enc_b = 1'b0;
    cyc(8);
    clr();
    enc_a = 1'b1; cyc(1);
    enc_a = 1'b0; cyc(1);
    enc_a = 1'b1; cyc(1);
    enc_a = 1'b0; cyc(1);
    enc_a = 1'b1; cyc(12);
    enc_a = 1'b0; cyc(12);
    chk("bounce_up", 32'(ups), 32'd1);
    chk("bounce_level", 32'(level), 32'd2);

    // 3-cycle glitch is one short of the debounce window.
    clr();
    enc_a = 1'b1; cyc(3);
    enc_a = 1'b0; cyc(12);
    chk("glitch_up", 32'(ups), 32'd0);
    chk("glitch_down", 32'(dns), 32'd0);
    chk("glitch_level", 32'(level), 32'd2);

    // Reset on the third debounce-count edge discards the pending step.
    enc_a = 1'b1;
    cyc(4);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    clr();
    chk("middb_reset_level", 32'(level), 32'd0);
    cyc(6);
    chk("middb_edge6_level", 32'(level), 32'd0);
    chk("middb_edge6_up", 32'(ups), 32'd0);
    cyc(1);
    chk("middb_edge7_level", 32'(level), 32'd1);
    chk("middb_edge7_up", 32'(step_up), 32'd1);
    enc_a = 1'b0;
    cyc(12);

    // Wrap instance: 240 + 16 -> 0, then 0 - 16 -> 240.
    clr();
    w_a = 1'b1; cyc(10);
    w_a = 1'b0; cyc(10);
    chk("wrap_up_level", 32'(w_level), 32'd0);
    chk("wrap_up_pulse", 32'(wups), 32'd1);
    w_b = 1'b1; cyc(10);
    clr();
    w_a = 1'b1; cyc(10);
    w_a = 1'b0; cyc(10);
    chk("wrap_down_level", 32'(w_level), 32'd240);
    chk("wrap_down_pulse", 32'(wdns), 32'd1);

    // Clamp at 0, then climb to 255 and clamp there.
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    enc_b = 1'b1;
    cyc(10);
    clr();
    detent();
    chk("sat_low_level", 32'(level), 32'd0);
    chk("sat_low_down", 32'(dns), 32'd1);
    enc_b = 1'b0;
    cyc(10);
    clr();
    for (int i = 0; i < 255; i++) detent();
    chk("sat_preload_level", 32'(level), 32'd255);
    chk("sat_preload_ups", 32'(ups), 32'd255);
    clr();
    detent();
    chk("sat_high_level", 32'(level), 32'd255);
    chk("sat_high_up", 32'(ups), 32'd1);

    chk("never_both", 32'(both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
